// File: rtl/uc_pkg.sv
// Shared definitions for the single-cycle CPU control unit: opcode constants,
// instruction-class masks, FSM states and the datapath control word.
package uc_pkg;

    localparam logic [5:0] OP_J    = 6'b000000;
    localparam logic [5:0] OP_JZ   = 6'b000001;
    localparam logic [5:0] OP_JNZ  = 6'b000010;
    localparam logic [5:0] OP_NOP  = 6'b000011;
    localparam logic [5:0] OP_HALT = 6'b001111;

    // Class patterns: (opcode & MASK) == MATCH
    localparam logic [5:0] ALU_MASK  = 6'b100000;
    localparam logic [5:0] ALU_MATCH = 6'b100000;
    localparam logic [5:0] LI_MASK   = 6'b111100;
    localparam logic [5:0] LI_MATCH  = 6'b000100;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op_alu;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/uc_dec_instr.sv
// Combinational instruction decoder: opcode and zero flag to datapath control
// word, plus strobes for illegal and HALT opcodes.
module dec_instr
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       illegal_op,
    output logic       halt_op
);

    always_comb begin
        ctrl            = CTRL_IDLE;
        ctrl.s_inc      = 1'b1;
        illegal_op      = 1'b0;
        halt_op         = 1'b0;

        if ((opcode & ALU_MASK) == ALU_MATCH) begin
            ctrl.op_alu = opcode[4:2];
            ctrl.we3    = 1'b1;
            ctrl.wez    = 1'b1;
        end else if ((opcode & LI_MASK) == LI_MATCH) begin
            ctrl.we3    = 1'b1;
            ctrl.s_inm  = 1'b1;
        end else begin
            unique case (opcode)
                OP_J:    ctrl.s_inc = 1'b0;
                OP_JZ:   ctrl.s_inc = ~z;
                OP_JNZ:  ctrl.s_inc = z;
                OP_NOP:  ctrl.s_inc = 1'b1;
                OP_HALT: begin
                    // HALT jumps to its own address so the PC holds
                    ctrl.s_inc = 1'b0;
                    halt_op    = 1'b1;
                end
                default: illegal_op = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc.sv
// Control unit top: run/halt FSM, HALT-state output override, sticky illegal
// flag and saturating retired-instruction counter around the decoder.
module uc
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op_alu,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl;
    logic             illegal_op;
    logic             halt_op;
    state_t           state;
    state_t           state_nxt;
    logic             illegal_r;
    logic [CNT_W-1:0] retired_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    dec_instr u_dec (
        .opcode     (opcode),
        .z          (z),
        .ctrl       (dec_ctrl),
        .illegal_op (illegal_op),
        .halt_op    (halt_op)
    );

    always_comb begin
        state_nxt = state;
        ctrl      = dec_ctrl;
        unique case (state)
            RUN:  if (halt_op) state_nxt = HALT;
            HALT: ctrl = CTRL_IDLE;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            illegal_r <= 1'b0;
            retired_r <= '0;
        end else begin
            state <= state_nxt;
            // Only instructions executed in RUN retire or can flag illegal
            if (state == RUN) begin
                if (illegal_op) illegal_r <= 1'b1;
                retired_r <= sat_inc(retired_r);
            end
        end
    end

    assign s_inc   = ctrl.s_inc;
    assign s_inm   = ctrl.s_inm;
    assign we3     = ctrl.we3;
    assign wez     = ctrl.wez;
    assign op_alu  = ctrl.op_alu;
    assign halted  = (state == HALT);
    assign illegal = illegal_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_uc.sv
// Self-checking bench for uc: default instance plus a 4-bit counter instance
// sharing the same stimulus, both checked against a behavioural model.
module tb_uc;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        z;

    logic        s_inc, s_inm, we3, wez;
    logic [2:0]  op_alu;
    logic        halted, illegal;
    logic [15:0] retired;

    logic        q_s_inc, q_s_inm, q_we3, q_wez;
    logic [2:0]  q_op_alu;
    logic        q_halted, q_illegal;
    logic [3:0]  q_retired;

    int total = 0;
    int bad   = 0;

    // model state
    bit m_halt = 0;
    bit m_ill  = 0;
    int m_ret  = 0;

    always #5 clk = ~clk;

    uc #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op_alu(op_alu),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    uc #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z),
        .s_inc(q_s_inc), .s_inm(q_s_inm), .we3(q_we3), .wez(q_wez), .op_alu(q_op_alu),
        .halted(q_halted), .illegal(q_illegal), .retired(q_retired)
    );

    wire [6:0] ctrl_obs = {s_inc, s_inm, we3, wez, op_alu};

    // Expected {s_inc, s_inm, we3, wez, op_alu} from the instruction-class rules
    function automatic logic [6:0] exp_ctrl(input logic [5:0] op, input logic zz, input bit hlt);
        int v;
        v = int'(op);
        if (hlt)                return 7'b0000_000;
        if (v >= 32)            return {4'b1011, 3'(v / 4 % 8)};
        if (v >= 4 && v <= 7)   return 7'b1110_000;
        if (v == 0)             return 7'b0000_000;
        if (v == 1)             return {~zz, 6'b000_000};
        if (v == 2)             return {zz, 6'b000_000};
        if (v == 3)             return 7'b1000_000;
        if (v == 15)            return 7'b0000_000;
        return 7'b1000_000;
    endfunction

    function automatic bit is_illegal(input logic [5:0] op);
        int v;
        v = int'(op);
        return (v < 32) && (v > 7) && (v != 15);
    endfunction

    function automatic int cap(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Advance one clock and update the model from the inputs applied at that edge
    task automatic tick();
        bit nh, ni;
        int nr;
        if (reset) begin
            nh = 0; ni = 0; nr = 0;
        end else if (m_halt) begin
            nh = 1; ni = m_ill; nr = m_ret;
        end else begin
            nh = (opcode == 6'd15);
            ni = m_ill | is_illegal(opcode);
            nr = m_ret + 1;
        end
        @(posedge clk);
        m_halt = nh; m_ill = ni; m_ret = nr;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        opcode = 6'd3;
        z = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'd3; z = 1'b0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (halted !== 1'b0 || illegal !== 1'b0 || retired !== 16'd0) begin
            bad++;
            $display("FAIL reset_state got halted=%b illegal=%b retired=%0d want 0 0 0", halted, illegal, retired);
        end
        total++;
        if (q_halted !== 1'b0 || q_illegal !== 1'b0 || q_retired !== 4'd0) begin
            bad++;
            $display("FAIL reset_state_sat got halted=%b illegal=%b retired=%0d want 0 0 0", q_halted, q_illegal, q_retired);
        end
    endtask

    task automatic test_alu_sweep();
        logic [6:0] exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            opcode = {1'b1, 3'(i), 2'($urandom_range(0, 3))};
            z = 1'($urandom);
            exp = {4'b1011, 3'(i)};
            @(negedge clk);
            total++;
            if (ctrl_obs !== exp) begin
                bad++;
                $display("FAIL alu_sweep op=%b got=%b want=%b", opcode, ctrl_obs, exp);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (retired !== 16'(m_ret) || m_ret != 8) begin
            bad++;
            $display("FAIL alu_retired got=%0d want=8", retired);
        end
    endtask

    task automatic test_li_jumps();
        logic [5:0] ops [4] = '{6'b000100, 6'b000111, 6'b000000, 6'b000011};
        logic [6:0] exp;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            z = 1'b1;
            exp = exp_ctrl(opcode, z, m_halt);
            @(negedge clk);
            total++;
            if (ctrl_obs !== exp) begin
                bad++;
                $display("FAIL li_jump op=%b got=%b want=%b", opcode, ctrl_obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_branches();
        logic [6:0] exp;
        for (int i = 0; i < 4; i++) begin
            opcode = (i < 2) ? 6'd1 : 6'd2;
            z = 1'(i % 2);
            // JZ taken (s_inc=0) when z=1; JNZ taken when z=0
            exp = {((opcode == 6'd1) ? (z == 1'b0) : (z == 1'b1)), 6'b0};
            @(negedge clk);
            total++;
            if (ctrl_obs !== exp) begin
                bad++;
                $display("FAIL branch op=%b z=%b got=%b want=%b", opcode, z, ctrl_obs, exp);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 6'b010101; z = 1'b0;
        @(negedge clk);
        total++;
        if (ctrl_obs !== 7'b1000_000 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_exec got ctrl=%b ill=%b want ctrl=1000000 ill=0", ctrl_obs, illegal);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            opcode = (i % 2) ? 6'd3 : 6'($urandom_range(32, 63));
            @(negedge clk);
            total++;
            if (illegal !== 1'b1) begin
                bad++;
                $display("FAIL illegal_sticky cycle=%0d got=%b want=1", i, illegal);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (retired !== 16'd11) begin
            bad++;
            $display("FAIL illegal_retired got=%0d want=11", retired);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 300; i++) begin
            opcode = 6'($urandom);
            if (opcode == 6'd15) opcode = 6'd3;
            z = 1'($urandom);
            exp = exp_ctrl(opcode, z, m_halt);
            @(negedge clk);
            total++;
            if (ctrl_obs !== exp || illegal !== m_ill || retired !== 16'(m_ret) || halted !== m_halt) begin
                bad++;
                errs++;
                if (errs < 5)
                    $display("FAIL random op=%b z=%b ctrl=%b/%b ill=%b/%b ret=%0d/%0d", opcode, z, ctrl_obs, exp, illegal, m_ill, retired, m_ret);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        int frozen;
        do_reset();
        opcode = 6'd3; tick(); tick();
        opcode = 6'd15; z = 1'b1;
        @(negedge clk);
        total++;
        if (ctrl_obs !== 7'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_decode got ctrl=%b halted=%b want 0000000 0", ctrl_obs, halted);
        end
        tick();
        frozen = m_ret;
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || retired !== 16'd3) begin
            bad++;
            $display("FAIL halt_enter got halted=%b retired=%0d want 1 3", halted, retired);
        end
        for (int i = 0; i < 6; i++) begin
            opcode = (i == 5) ? 6'b011000 : 6'($urandom_range(32, 63));
            @(negedge clk);
            total++;
            if (ctrl_obs !== 7'b0 || halted !== 1'b1 || retired !== 16'(frozen)) begin
                bad++;
                $display("FAIL halt_hold op=%b got ctrl=%b halted=%b ret=%0d want 0 1 %0d", opcode, ctrl_obs, halted, retired, frozen);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (illegal !== 1'b0) begin
            bad++;
            $display("FAIL halt_illegal_ignored got=%b want=0", illegal);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (halted !== 1'b0 || retired !== 16'd0) begin
            bad++;
            $display("FAIL halt_reset got halted=%b retired=%0d want 0 0", halted, retired);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        opcode = 6'd3; z = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            total++;
            if (q_retired !== 4'(cap(k, 15)) || retired !== 16'(k)) begin
                bad++;
                $display("FAIL saturate k=%0d got sat=%0d wide=%0d want %0d %0d", k, q_retired, retired, cap(k, 15), k);
            end
            tick();
        end
        opcode = 6'b001000;
        tick();
        opcode = 6'd3;
        @(negedge clk);
        total++;
        if (q_retired !== 4'hF || q_illegal !== 1'b1) begin
            bad++;
            $display("FAIL sat_illegal got ret=%0d ill=%b want 15 1", q_retired, q_illegal);
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = 6'd3;
        z = 1'b0;
        test_reset();
        test_alu_sweep();
        test_li_jumps();
        test_branches();
        test_illegal();
        test_random();
        test_halt();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
